atomic_unit: RTL and testbench

ATOMIC_UNIT -- requirements
Module: atomic_unit

---
 rtl/amo_pkg.sv | 42 ++++
 rtl/amo_alu.sv | 39 +++
 rtl/atomic_unit.sv | 182 ++++++++++++++++++
 tb/tb_atomic_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amo_pkg
// Description : Shared definitions for the RV32A atomic unit: AMO opcode and
//               funct3, funct5 encodings, FSM state enum and a legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package amo_pkg;

    localparam logic [6:0] OPCODE_AMO = 7'b0101111;
    localparam logic [2:0] FUNCT3_W   = 3'd2;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_ALU    = 3'd2,
        ST_WR_REQ = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    function automatic logic is_legal_f5(input logic [4:0] f5);
        case (f5)
            F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: is_legal_f5 = 1'b1;
            default:                          is_legal_f5 = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/amo_alu.sv
`default_nettype none
// ============================================================================
// Module      : amo_alu
// Description : Combinational read-modify-write operator for AMOs.
//               funct5_i  : AMO funct5 selecting the operation
//               old_i     : value read from memory
//               operand_i : rs2 source operand
//               result_o  : value to be written back
// Revision    : 1.0 - initial release
// ============================================================================
module amo_alu
    import amo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [4:0]            funct5_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    always_comb begin
        result_o = old_i;
        case (funct5_i)
            F5_SWAP: result_o = operand_i;
            F5_ADD:  result_o = old_i + operand_i;
            F5_XOR:  result_o = old_i ^ operand_i;
            F5_AND:  result_o = old_i & operand_i;
            F5_OR:   result_o = old_i | operand_i;
            F5_MIN:  result_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
            F5_MAX:  result_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
            F5_MINU: result_o = (old_i < operand_i) ? old_i : operand_i;
            F5_MAXU: result_o = (old_i > operand_i) ? old_i : operand_i;
            default: result_o = old_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/atomic_unit.sv
`default_nettype none
// ============================================================================
// Module      : atomic_unit
// Description : RV32A word atomic execution unit (LR.W, SC.W, AMO*.W) driving
//               a single-word memory request/ack interface.
//   start/instr/rs1_data/rs2_data : instruction issue (accepted only when idle)
//   reserved                      : reservation hit for the current SC.W
//   mem_req/we/addr/wdata         : memory request, held until mem_ack
//   mem_ack/mem_rdata             : memory response
//   busy/done/misaligned/rd_data  : status and one-cycle result
// Revision    : 1.0 - initial release
// ============================================================================
module atomic_unit
    import amo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  reserved,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned,
    output logic [DATA_WIDTH-1:0] rd_data
);

    state_t                state_q;
    logic [4:0]            funct5_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  misaligned_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [4:0]            w_funct5;
    logic                  w_misaligned;
    logic                  w_legal;
    logic [DATA_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_unused_instr;

    assign w_funct5     = instr[31:27];
    assign w_misaligned = (rs1_data[1:0] != 2'b00);
    assign w_legal      = (instr[6:0] == OPCODE_AMO) && (instr[14:12] == FUNCT3_W)
                          && is_legal_f5(w_funct5);
    assign w_addr       = {rs1_data[DATA_WIDTH-1:2], 2'b00};
    // aq/rl and register-index fields have no effect inside this unit
    assign w_unused_instr = ^{instr[26:15], instr[11:7]};

    amo_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .funct5_i  (funct5_q),
        .old_i     (old_q),
        .operand_i (operand_q),
        .result_o  (w_alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            funct5_q     <= '0;
            operand_q    <= '0;
            old_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        funct5_q  <= w_funct5;
                        operand_q <= rs2_data;
                        busy_q    <= 1'b1;
                        // Misalignment takes priority over every other outcome
                        if (w_misaligned) begin
                            misaligned_q <= 1'b1;
                            rd_data_q    <= '0;
                            done_q       <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (!w_legal) begin
                            rd_data_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= ST_RESP;
                        end else if (w_funct5 == F5_SC) begin
                            if (reserved) begin
                                mem_req_q   <= 1'b1;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= w_addr;
                                mem_wdata_q <= rs2_data;
                                state_q     <= ST_WR_REQ;
                            end else begin
                                rd_data_q <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                                done_q    <= 1'b1;
                                state_q   <= ST_RESP;
                            end
                        end else begin
                            // LR and all read-modify-write AMOs start with a read
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= w_addr;
                            state_q    <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (funct5_q == F5_LR) begin
                            rd_data_q <= mem_rdata;
                            done_q    <= 1'b1;
                            state_q   <= ST_RESP;
                        end else begin
                            old_q   <= mem_rdata;
                            state_q <= ST_ALU;
                        end
                    end
                end
                ST_ALU: begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= w_alu_result;
                    state_q     <= ST_WR_REQ;
                end
                ST_WR_REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        // A successful SC returns 0; AMOs return the old value
                        rd_data_q <= (funct5_q == F5_SC) ? '0 : old_q;
                        done_q    <= 1'b1;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    done_q       <= 1'b0;
                    misaligned_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = misaligned_q;
    assign rd_data    = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_atomic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_atomic_unit
// Description : Directed self-checking bench for atomic_unit with a
//               word-memory responder of programmable ack latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atomic_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        reserved = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy, done, misaligned;
    logic [31:0] rd_data;

    atomic_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .reserved   (reserved),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem [0:255];
    int          rd_delay = 0;
    int          wr_delay = 0;
    int          wait_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_ra = '0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_req) begin
            if (wait_cnt >= (mem_we ? wr_delay : rd_delay)) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    wr_cnt++;
                    last_wa = mem_addr;
                    last_wd = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr[9:2]];
                    rd_cnt++;
                    last_ra = mem_addr;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] f5);
        mk = {f5, 2'b00, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0101111};
    endfunction

    // Issue one instruction and follow it to done.
    task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic rsv, input int rdly, input int wdly,
                          input bit pulse, input int exp_rd, input int exp_wr,
                          output int cyc, output logic [31:0] rdv, output logic mis);
        int rd0, wr0, rd_req_cyc, wr_req_cyc;
        bit got_done;
        rd_delay = rdly;
        wr_delay = wdly;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        rd_req_cyc = 0;
        wr_req_cyc = 0;
        got_done = 1'b0;
        cyc = 0;
        rdv = '0;
        mis = 1'b0;
        @(negedge clk);
        start = 1'b1; instr = ins; rs1_data = a; rs2_data = b; reserved = rsv;
        while (!got_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            reserved = 1'b0;
            if (pulse && (cyc == 2 || cyc == 5)) begin
                // issue a different request while busy; it must be ignored
                start = 1'b1; instr = mk(5'b00000); rs1_data = 32'h0000_0300;
                rs2_data = 32'h0000_0001;
            end
            if (mem_req && !mem_we) begin
                rd_req_cyc++;
                chk({tag, "_rd_addr_hold"}, mem_addr, {a[31:2], 2'b00});
            end
            if (mem_req && mem_we) wr_req_cyc++;
            if (done) begin
                got_done = 1'b1;
                rdv = rd_data;
                mis = misaligned;
                chk({tag, "_busy_in_resp"}, {31'd0, busy}, 32'd1);
            end
        end
        start = 1'b0;
        if (!got_done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        chk({tag, "_reads"}, rd_cnt - rd0, exp_rd);
        chk({tag, "_writes"}, wr_cnt - wr0, exp_wr);
        chk({tag, "_rd_req_cycles"}, rd_req_cyc, exp_rd * (rdly + 1));
        chk({tag, "_wr_req_cycles"}, wr_req_cyc, exp_wr * (wdly + 1));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
    endtask

    typedef struct {
        logic [4:0]  f5;
        logic [31:0] old;
        logic [31:0] op;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [9];

    initial begin
        int          cyc;
        logic [31:0] rdv;
        logic        mis;
        int          wr_snap;
        bit          seen;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        vt[0] = '{5'b10000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF}; // MIN
        vt[1] = '{5'b11000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001}; // MINU
        vt[2] = '{5'b10100, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0005}; // MAX
        vt[3] = '{5'b11100, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF}; // MAXU
        vt[4] = '{5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0}; // XOR
        vt[5] = '{5'b01100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000}; // AND
        vt[6] = '{5'b01000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0}; // OR
        vt[7] = '{5'b10000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000}; // MIN
        vt[8] = '{5'b11000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF}; // MINU

        // Reset state
        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_flags", {29'd0, busy, done, misaligned}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // AMOADD with wrap into the sign bit
        mem[8'h40] = 32'h7FFF_FFFF;
        run_op("add", mk(5'b00000), 32'h100, 32'h1, 1'b0, 0, 0, 1'b0, 1, 1, cyc, rdv, mis);
        chk("add_latency", cyc, 4);
        chk("add_rd_data", rdv, 32'h7FFF_FFFF);
        chk("add_read_addr", last_ra, 32'h100);
        chk("add_write_addr", last_wa, 32'h100);
        chk("add_write_data", last_wd, 32'h8000_0000);

        // Operator table
        for (int i = 0; i < 9; i++) begin
            mem[8'h50 + i] = vt[i].old;
            run_op($sformatf("alu%0d", i), mk(vt[i].f5), 32'h140 + 32'(i * 4), vt[i].op,
                   1'b0, 0, 0, 1'b0, 1, 1, cyc, rdv, mis);
            chk($sformatf("alu%0d_rd_data", i), rdv, vt[i].old);
            chk($sformatf("alu%0d_write", i), mem[8'h50 + i], vt[i].exp);
        end

        // SC.W with reservation
        run_op("sc_ok", mk(5'b00011), 32'h40, 32'hDEAD, 1'b1, 0, 0, 1'b0, 0, 1, cyc, rdv, mis);
        chk("sc_ok_latency", cyc, 2);
        chk("sc_ok_rd_data", rdv, 32'd0);
        chk("sc_ok_wdata", last_wd, 32'hDEAD);
        chk("sc_ok_waddr", last_wa, 32'h40);

        // SC.W without reservation
        mem[8'h10] = 32'h0000_1111;
        run_op("sc_fail", mk(5'b00011), 32'h40, 32'hBEEF, 1'b0, 0, 0, 1'b0, 0, 0, cyc, rdv, mis);
        chk("sc_fail_latency", cyc, 1);
        chk("sc_fail_rd_data", rdv, 32'd1);
        chk("sc_fail_mem", mem[8'h10], 32'h0000_1111);

        // LR.W aligned and misaligned
        mem[8'h10] = 32'h0000_CAFE;
        run_op("lr", mk(5'b00010), 32'h40, 32'h0, 1'b0, 0, 0, 1'b0, 1, 0, cyc, rdv, mis);
        chk("lr_latency", cyc, 2);
        chk("lr_rd_data", rdv, 32'h0000_CAFE);
        chk("lr_misaligned", {31'd0, mis}, 32'd0);
        run_op("lr_mis", mk(5'b00010), 32'h42, 32'h0, 1'b0, 0, 0, 1'b0, 0, 0, cyc, rdv, mis);
        chk("lr_mis_latency", cyc, 1);
        chk("lr_mis_flag", {31'd0, mis}, 32'd1);

        // Illegal funct5
        run_op("illegal", mk(5'b11111), 32'h40, 32'h5, 1'b0, 0, 0, 1'b0, 0, 0, cyc, rdv, mis);
        chk("illegal_latency", cyc, 1);
        chk("illegal_rd_data", rdv, 32'd0);
        chk("illegal_misaligned", {31'd0, mis}, 32'd0);

        // AMOSWAP with a 3-cycle read wait and start pulses while busy
        mem[8'h80] = 32'h0000_1234;
        run_op("swap", mk(5'b00001), 32'h200, 32'h0000_AAAA, 1'b0, 3, 0, 1'b1, 1, 1, cyc, rdv, mis);
        chk("swap_latency", cyc, 7);
        chk("swap_rd_data", rdv, 32'h0000_1234);
        chk("swap_mem", mem[8'h80], 32'h0000_AAAA);
        repeat (3) @(negedge clk);
        chk("swap_no_extra_op", {31'd0, busy}, 32'd0);

        // Reset while in WR_REQ
        mem[8'hC0] = 32'h0000_0055;
        rd_delay = 0;
        wr_delay = 20;
        @(negedge clk);
        start = 1'b1; instr = mk(5'b00001); rs1_data = 32'h300; rs2_data = 32'h66;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_req && mem_we) seen = 1'b1;
        end
        chk("rstwr_reached_wr", {31'd0, seen}, 32'd1);
        wr_snap = wr_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rstwr_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstwr_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rstwr_addr_wdata", mem_addr | mem_wdata, 32'd0);
        chk("rstwr_flags", {29'd0, busy, done, misaligned}, 32'd0);
        chk("rstwr_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_delay = 0;
        repeat (8) @(negedge clk);
        chk("rstwr_no_write", wr_cnt - wr_snap, 0);
        chk("rstwr_mem_kept", mem[8'hC0], 32'h0000_0055);
        chk("rstwr_idle", {31'd0, busy}, 32'd0);
        run_op("post_rst", mk(5'b00000), 32'h300, 32'h1, 1'b0, 0, 0, 1'b0, 1, 1, cyc, rdv, mis);
        chk("post_rst_latency", cyc, 4);
        chk("post_rst_rd_data", rdv, 32'h0000_0055);
        chk("post_rst_mem", mem[8'hC0], 32'h0000_0056);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
